// File: rtl/bpm_sim_pkg.sv
// Shared types and constants for the BPM X/Y simulation buffer readers.
// FSM state encoding, RAM latency, address and counter widths.
package bpm_sim_pkg;

  localparam int BPM_RAM_LAT = 2;
  localparam int BPM_ADDR_W  = 12;
  localparam int BPM_OVR_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } frame_state_e;

endpackage

// File: rtl/bpm_rd_fifo.sv
// Show-ahead synchronous FIFO carrying a data word and its source address.
// Output data/address read as zero while the FIFO is empty.
module bpm_rd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       pop,
  output logic                       valid,
  output logic [DATA_W-1:0]          pop_data,
  output logic [ADDR_W-1:0]          pop_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr_q] <= push_data;
      addr_mem[wr_ptr_q] <= push_addr;
    end
  end

  assign valid    = (count_q != '0);
  assign pop_data = valid ? data_mem[rd_ptr_q] : '0;
  assign pop_addr = valid ? addr_mem[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/bpm_xy_frame_reader.sv
// Sweeps BPM X/Y buffer port B per trigger and streams tagged words out.
// Optional FrameChecksum output enabled by BPM_XY_FRAME_CHECKSUM_EN.
module bpm_xy_frame_reader
  import bpm_sim_pkg::*;
#(
  parameter int ADDR_W     = BPM_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = BPM_RAM_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trig,
  input  logic                 Enable,
  input  logic [ADDR_W-1:0]    StartAddr,
  input  logic [ADDR_W-1:0]    EndAddr,
  output logic                 DpRamB_Read,
  output logic [ADDR_W-1:0]    DpRamB_Address,
  input  logic [DATA_W-1:0]    PosXyData,
  output logic [DATA_W-1:0]    OutData,
  output logic [ADDR_W-1:0]    OutAddr,
  output logic                 OutIsY,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Busy,
  output logic                 FrameDone,
  output logic                 BadRange,
  output logic [BPM_OVR_W-1:0] TrigOverrunCnt
`ifdef BPM_XY_FRAME_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]    FrameChecksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  frame_state_e state_q, state_d;

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    end_q, end_d;
  logic                 rd_q, rd_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic                 done_q, done_d;
  logic                 bad_q, bad_d;
  logic                 busy_q, busy_d;
  logic [BPM_OVR_W-1:0] ovr_q, ovr_d;

  logic                 sr_vld_q  [RAM_LAT];
  logic [ADDR_W-1:0]    sr_addr_q [RAM_LAT];

  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 credit_ok;
  logic                 fifo_drained;
  logic [CNT_W-1:0]     fifo_count;

  assign push = sr_vld_q[RAM_LAT-1];
  assign pop  = OutValid && OutReady;

  // A pop this cycle frees a slot in time for a read issued now.
  assign credit_ok =
    (int'(fifo_count) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));

  assign fifo_drained =
    (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    rd_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    bad_d     = 1'b0;
    ovr_d     = ovr_q;
    issue     = 1'b0;

    if (trig && (state_q != IDLE) && (ovr_q != '1))
      ovr_d = ovr_q + BPM_OVR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (trig && Enable) begin
          if (EndAddr < StartAddr) begin
            state_d = DONE;
            done_d  = 1'b1;
            bad_d   = 1'b1;
          end else begin
            issue     = 1'b1;
            rd_d      = 1'b1;
            rd_addr_d = StartAddr;
            addr_d    = StartAddr + ADDR_W'(1);
            end_d     = EndAddr;
            state_d   = (StartAddr == EndAddr) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue     = 1'b1;
          rd_d      = 1'b1;
          rd_addr_d = addr_q;
          if (addr_q == end_q) state_d = DRAIN;
          else                 addr_d  = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && fifo_drained) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      rd_q       <= 1'b0;
      rd_addr_q  <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      rd_q       <= rd_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  // Read flag and address travel alongside the RAM's read pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        sr_vld_q[i]  <= 1'b0;
        sr_addr_q[i] <= '0;
      end
    end else begin
      sr_vld_q[0]  <= rd_q;
      sr_addr_q[0] <= rd_addr_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        sr_vld_q[i]  <= sr_vld_q[i-1];
        sr_addr_q[i] <= sr_addr_q[i-1];
      end
    end
  end

  bpm_rd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (PosXyData),
    .push_addr (sr_addr_q[RAM_LAT-1]),
    .pop       (pop),
    .valid     (OutValid),
    .pop_data  (OutData),
    .pop_addr  (OutAddr),
    .count     (fifo_count)
  );

  assign OutIsY         = OutAddr[0];
  assign DpRamB_Read    = rd_q;
  assign DpRamB_Address = rd_addr_q;
  assign Busy           = busy_q;
  assign FrameDone      = done_q;
  assign BadRange       = bad_q;
  assign TrigOverrunCnt = ovr_q;

`ifdef BPM_XY_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && trig && Enable) csum_d = '0;
    else if (pop)                            csum_d = csum_q + OutData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign FrameChecksum = csum_q;
`endif

endmodule
